// File: rtl/ddr2_arb_pkg.sv
// rtl/ddr2_arb_pkg.sv - shared types and field offsets for the DDR2 user-module arbiter
package ddr2_arb_pkg;

   localparam int CMD_W      = 34;
   localparam int CMD_OP     = 33;
   localparam int CMD_LEN_HI = 30;
   localparam int CMD_LEN_LO = 24;
   localparam int CMD_ADDR_HI = 23;
   localparam int DATA_W     = 128;
   localparam int LEN_W      = 7;
   localparam int ADDR_W     = 24;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WDATA = 2'd1,
      S_CMD   = 2'd2
   } issue_state_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_LEN  = 2'd1,
      R_DATA = 2'd2
   } ret_state_t;

   typedef logic port_id_t;

   typedef struct packed {
      port_id_t           id;
      logic [LEN_W-1:0]   beats;
   } ord_entry_t;

   // A zero beat count is treated as a single beat everywhere.
   function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len);
      return (len == '0) ? LEN_W'(1) : len;
   endfunction

endpackage

// File: rtl/ddr2_arb_ord_fifo.sv
// rtl/ddr2_arb_ord_fifo.sv - in-order tag FIFO of {port id, beats} for outstanding reads
module ddr2_arb_ord_fifo
   import ddr2_arb_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_push,
   input  ord_entry_t i_wr_entry,
   input  logic       i_pop,
   output ord_entry_t o_rd_entry,
   output logic       o_full,
   output logic       o_empty
);

   ord_entry_t    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (AW+1)'(DEPTH));

   // Push and pop together always succeed: at empty the entry bypasses, at full a slot frees.
   assign w_do_pop   = i_pop  & (!o_empty | i_push);
   assign w_do_push  = i_push & (!o_full  | i_pop);
   assign o_rd_entry = o_empty ? i_wr_entry : r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wr_entry;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/ddr2_um_arbiter.sv
// rtl/ddr2_um_arbiter.sv - two-port round-robin arbiter in front of the DDR2 user-module FIFOs
module ddr2_um_arbiter
   import ddr2_arb_pkg::*;
#(
   parameter int ORD_DEPTH = 16,
   parameter int ORD_AW    = 4
) (
   input  logic                i_sysclk,
   input  logic                i_sys_rst,
   input  logic                i_req0_cmd_valid,
   input  logic [CMD_W-1:0]    i_req0_cmd,
   output logic                o_req0_cmd_ready,
   input  logic                i_req0_wdata_valid,
   input  logic [DATA_W-1:0]   i_req0_wdata,
   output logic                o_req0_wdata_ready,
   output logic                o_req0_rdata_valid,
   output logic [DATA_W-1:0]   o_req0_rdata,
   input  logic                i_req1_cmd_valid,
   input  logic [CMD_W-1:0]    i_req1_cmd,
   output logic                o_req1_cmd_ready,
   input  logic                i_req1_wdata_valid,
   input  logic [DATA_W-1:0]   i_req1_wdata,
   output logic                o_req1_wdata_ready,
   output logic                o_req1_rdata_valid,
   output logic [DATA_W-1:0]   o_req1_rdata,
   output logic                o_um2ddr_wrreq,
   output logic [DATA_W-1:0]   o_um2ddr_data,
   input  logic                i_um2ddr_ready,
   output logic                o_um2ddr_command_wrreq,
   output logic [CMD_W-1:0]    o_um2ddr_command,
   output logic                o_ddr2um_rdreq,
   input  logic [DATA_W-1:0]   i_ddr2um_rdata,
   output logic                o_ddr2um_valid_rdreq,
   input  logic [LEN_W-1:0]    i_ddr2um_valid_rdata,
   input  logic                i_ddr2um_valid_empty,
   output logic                o_err_orphan
);

   issue_state_t        r_state;
   port_id_t            r_port;
   port_id_t            r_rr_ptr;
   logic                r_is_wr;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_beat;
   logic [ADDR_W-1:0]   r_addr;

   ret_state_t          r_rstate;
   logic [LEN_W-1:0]    r_rcnt;
   port_id_t            r_rport;
   logic                r_drop;
   logic                r_rvalid0;
   logic                r_rvalid1;
   logic                r_err;

   logic [1:0]          w_cmd_valid;
   port_id_t            w_grant_id;
   logic                w_grant;
   logic [CMD_W-1:0]    w_sel_cmd;
   logic                w_in_wdata;
   logic                w_wvalid;
   logic                w_cmd_push;
   logic                w_tag_push;
   logic                w_tag_pop;
   logic                w_orphan;
   logic                w_ord_full;
   logic                w_ord_empty;
   ord_entry_t          w_ord_wr;
   ord_entry_t          w_ord_rd;
   logic                w_unused;

   // Issue side: round-robin grant, write beats first, then the command push.
   assign w_cmd_valid = {i_req1_cmd_valid, i_req0_cmd_valid};
   assign w_grant_id  = w_cmd_valid[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
   assign w_grant     = (r_state == S_IDLE) & (|w_cmd_valid) & !i_sys_rst;
   assign w_sel_cmd   = w_grant_id ? i_req1_cmd : i_req0_cmd;

   assign o_req0_cmd_ready = w_grant & (w_grant_id == 1'b0);
   assign o_req1_cmd_ready = w_grant & (w_grant_id == 1'b1);

   assign w_in_wdata         = (r_state == S_WDATA) & !i_sys_rst;
   assign w_wvalid           = r_port ? i_req1_wdata_valid : i_req0_wdata_valid;
   assign o_req0_wdata_ready = w_in_wdata & (r_port == 1'b0) & i_um2ddr_ready;
   assign o_req1_wdata_ready = w_in_wdata & (r_port == 1'b1) & i_um2ddr_ready;
   assign o_um2ddr_wrreq     = w_in_wdata & w_wvalid & i_um2ddr_ready;
   assign o_um2ddr_data      = w_in_wdata ? (r_port ? i_req1_wdata : i_req0_wdata) : '0;

   assign w_cmd_push = (r_state == S_CMD) & !i_sys_rst & i_um2ddr_ready & (r_is_wr | !w_ord_full);
   assign w_tag_push = w_cmd_push & !r_is_wr;
   assign w_ord_wr   = {r_port, r_len};

   assign o_um2ddr_command_wrreq = w_cmd_push;
   assign o_um2ddr_command       = w_cmd_push ? {r_is_wr, 2'b00, r_len, r_addr} : '0;

   always_ff @(posedge i_sysclk) begin
      if (i_sys_rst) begin
         r_state  <= S_IDLE;
         r_port   <= 1'b0;
         r_rr_ptr <= 1'b0;
         r_is_wr  <= 1'b0;
         r_len    <= '0;
         r_beat   <= '0;
         r_addr   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_port   <= w_grant_id;
                  r_rr_ptr <= ~w_grant_id;
                  r_is_wr  <= w_sel_cmd[CMD_OP];
                  r_len    <= norm_len(w_sel_cmd[CMD_LEN_HI:CMD_LEN_LO]);
                  r_addr   <= w_sel_cmd[CMD_ADDR_HI:0];
                  r_beat   <= '0;
                  r_state  <= w_sel_cmd[CMD_OP] ? S_WDATA : S_CMD;
               end
            end
            S_WDATA: begin
               if (o_um2ddr_wrreq) begin
                  if (r_beat == r_len - LEN_W'(1)) begin
                     r_state <= S_CMD;
                  end else begin
                     r_beat <= r_beat + LEN_W'(1);
                  end
               end
            end
            S_CMD: begin
               if (w_cmd_push) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   ddr2_arb_ord_fifo #(
      .DEPTH (ORD_DEPTH),
      .AW    (ORD_AW)
   ) u_ord_fifo (
      .i_clk      (i_sysclk),
      .i_rst      (i_sys_rst),
      .i_push     (w_tag_push),
      .i_wr_entry (w_ord_wr),
      .i_pop      (w_tag_pop),
      .o_rd_entry (w_ord_rd),
      .o_full     (w_ord_full),
      .o_empty    (w_ord_empty)
   );

   // Return side: the valid FIFO's beat count governs; the tag only selects the port.
   assign o_ddr2um_valid_rdreq = (r_rstate == R_IDLE) & !i_ddr2um_valid_empty & !i_sys_rst;
   assign w_tag_pop            = (r_rstate == R_LEN) & !i_sys_rst;
   assign w_orphan             = w_ord_empty & !w_tag_push;
   assign o_ddr2um_rdreq       = (r_rstate == R_DATA) & !i_sys_rst;

   assign o_req0_rdata_valid = r_rvalid0;
   assign o_req1_rdata_valid = r_rvalid1;
   assign o_req0_rdata       = r_rvalid0 ? i_ddr2um_rdata : '0;
   assign o_req1_rdata       = r_rvalid1 ? i_ddr2um_rdata : '0;
   assign o_err_orphan       = r_err;

   always_ff @(posedge i_sysclk) begin
      if (i_sys_rst) begin
         r_rstate  <= R_IDLE;
         r_rcnt    <= '0;
         r_rport   <= 1'b0;
         r_drop    <= 1'b0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_rvalid0 <= o_ddr2um_rdreq & !r_drop & (r_rport == 1'b0);
         r_rvalid1 <= o_ddr2um_rdreq & !r_drop & (r_rport == 1'b1);
         case (r_rstate)
            R_IDLE: begin
               if (o_ddr2um_valid_rdreq) begin
                  r_rstate <= R_LEN;
               end
            end
            R_LEN: begin
               r_rcnt   <= norm_len(i_ddr2um_valid_rdata);
               r_rport  <= w_ord_rd.id;
               r_drop   <= w_orphan;
               if (w_orphan) begin
                  r_err <= 1'b1;
               end
               r_rstate <= R_DATA;
            end
            R_DATA: begin
               if (r_rcnt == LEN_W'(1)) begin
                  r_rstate <= R_IDLE;
               end else begin
                  r_rcnt <= r_rcnt - LEN_W'(1);
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   assign w_unused = ^{w_ord_rd.beats, w_sel_cmd[32:31]};

endmodule
